// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid FIFO, branch-condition evaluation, NZCV status (+ sticky overflow under STICKY_OVF_EN).
// Latency 1 cycle into an empty FIFO; in_ready is registered (count<2) with no combinational path from out_ready.
module alu_result_stage #(
   parameter int         WIDTH      = 32,
   parameter logic [3:0] RESET_NZCV = 4'b0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_zero,
   input  logic             in_negative,
   input  logic             in_carry,
   input  logic             in_overflow,
   input  logic             in_update_flags,
   input  logic [2:0]       in_cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_taken,
   output logic [3:0]       status_nzcv,
   output logic             sticky_ovf,
   input  logic             clear_sticky
);

   localparam logic [2:0] COND_EQ  = 3'b000;
   localparam logic [2:0] COND_NE  = 3'b001;
   localparam logic [2:0] COND_LT  = 3'b010;
   localparam logic [2:0] COND_GE  = 3'b011;
   localparam logic [2:0] COND_LTU = 3'b100;
   localparam logic [2:0] COND_GEU = 3'b101;
   localparam logic [2:0] COND_AL  = 3'b110;

   logic [WIDTH-1:0] res_q [2];
   logic [1:0]       taken_q;
   logic [1:0]       count_q, count_nxt;
   logic             wr_ptr_q, rd_ptr_q;
   logic             in_ready_q;
   logic [3:0]       nzcv_q;
   logic [3:0]       flags;
   logic             taken_nxt;
   logic             accept, deliver;

   assign accept  = in_valid & in_ready_q;
   assign deliver = out_valid & out_ready;

   // A beat that does not write flags sees the status left by every earlier accepted beat.
   always_comb begin
      flags     = in_update_flags ? {in_negative, in_zero, in_carry, in_overflow} : nzcv_q;
      taken_nxt = 1'b0;
      case (in_cond)
         COND_EQ:  taken_nxt = flags[2];
         COND_NE:  taken_nxt = ~flags[2];
         COND_LT:  taken_nxt = flags[3] ^ flags[0];
         COND_GE:  taken_nxt = ~(flags[3] ^ flags[0]);
         COND_LTU: taken_nxt = flags[1];
         COND_GEU: taken_nxt = ~flags[1];
         COND_AL:  taken_nxt = 1'b1;
         default:  taken_nxt = 1'b0;
      endcase
   end

   always_comb begin
      count_nxt = count_q;
      case ({accept, deliver})
         2'b10:   count_nxt = count_q + 2'd1;
         2'b01:   count_nxt = count_q - 2'd1;
         default: count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         in_ready_q <= 1'b1;
         nzcv_q     <= RESET_NZCV;
         taken_q    <= 2'b00;
         for (int i = 0; i < 2; i++) res_q[i] <= '0;
      end else begin
         count_q    <= count_nxt;
         in_ready_q <= (count_nxt != 2'd2);
         if (accept) begin
            res_q[wr_ptr_q]   <= in_result;
            taken_q[wr_ptr_q] <= taken_nxt;
            wr_ptr_q          <= ~wr_ptr_q;
            if (in_update_flags)
               nzcv_q <= {in_negative, in_zero, in_carry, in_overflow};
         end
         if (deliver)
            rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (count_q != 2'd0);
   assign out_result  = res_q[rd_ptr_q];
   assign out_taken   = taken_q[rd_ptr_q];
   assign status_nzcv = nzcv_q;

`ifdef STICKY_OVF_EN
   logic sticky_q;

   // Set has priority over clear so an overflow landing on the clear edge is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sticky_q <= 1'b0;
      else if (accept & in_update_flags & in_overflow)
         sticky_q <= 1'b1;
      else if (clear_sticky)
         sticky_q <= 1'b0;
   end

   assign sticky_ovf = sticky_q;
`else
   logic unused_clear_sticky;
   assign unused_clear_sticky = clear_sticky;
   assign sticky_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table plus hand-written backpressure, sticky and reset sequences.
module tb_alu_result_stage;

   localparam int W = 32;
   localparam logic [2:0] EQ = 3'b000, NE = 3'b001, LT = 3'b010, GE = 3'b011;
   localparam logic [2:0] LTU = 3'b100, GEU = 3'b101, AL = 3'b110, NV = 3'b111;

`ifdef STICKY_OVF_EN
   localparam bit STICKY_EN = 1'b1;
`else
   localparam bit STICKY_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready;
   logic [W-1:0] in_result = '0;
   logic in_zero = 1'b0, in_negative = 1'b0, in_carry = 1'b0, in_overflow = 1'b0;
   logic in_update_flags = 1'b0;
   logic [2:0] in_cond = 3'b000;
   logic out_valid, out_ready = 1'b0;
   logic [W-1:0] out_result;
   logic out_taken;
   logic [3:0] status_nzcv;
   logic sticky_ovf, clear_sticky = 1'b0;

   alu_result_stage #(.WIDTH(W), .RESET_NZCV(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_zero(in_zero), .in_negative(in_negative), .in_carry(in_carry),
      .in_overflow(in_overflow), .in_update_flags(in_update_flags), .in_cond(in_cond),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_taken(out_taken), .status_nzcv(status_nzcv),
      .sticky_ovf(sticky_ovf), .clear_sticky(clear_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         taken;
   } exp_t;

   typedef struct {
      logic [W-1:0] res;
      logic         n, z, c, v, upd;
      logic [2:0]   cond;
      logic         exp_taken;
      logic [3:0]   exp_nzcv;
   } vec_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic cur_taken = 1'b0;
   logic exp_sticky = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Accept/deliver are sampled mid-cycle and take effect on the following rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", {32'd0, out_result}, 64'hDEAD);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_result", {32'd0, out_result}, {32'd0, e.res});
               check("out_taken", {63'd0, out_taken}, {63'd0, e.taken});
            end
         end
         if (in_valid && in_ready)
            sb.push_back('{res: in_result, taken: cur_taken});
      end
   end

   task automatic drive(input logic [W-1:0] r, input logic n, z, c, v, upd,
                        input logic [2:0] cond, input logic exp_taken);
      in_result = r; in_negative = n; in_zero = z; in_carry = c; in_overflow = v;
      in_update_flags = upd; in_cond = cond; cur_taken = exp_taken;
      in_valid = 1'b1;
   endtask

   task automatic send(input logic [W-1:0] r, input logic n, z, c, v, upd,
                       input logic [2:0] cond, input logic exp_taken);
      int k;
      drive(r, n, z, c, v, upd, cond, exp_taken);
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   vec_t vt[13];

   initial begin
      // Expected status evolves from the reset value 0000 through the table.
      vt[0]  = '{32'h0000_0000, 0,1,0,0, 1, EQ,  1, 4'b0100};
      vt[1]  = '{32'h0000_0005, 0,0,0,0, 0, EQ,  1, 4'b0100};
      vt[2]  = '{32'h0000_0006, 0,0,0,0, 0, NE,  0, 4'b0100};
      vt[3]  = '{32'h0000_0007, 0,0,1,0, 1, LTU, 1, 4'b0010};
      vt[4]  = '{32'h0000_0107, 0,0,1,0, 1, GEU, 0, 4'b0010};
      vt[5]  = '{32'h0000_0207, 0,0,1,0, 1, NV,  0, 4'b0010};
      vt[6]  = '{32'hFFFF_FFFF, 1,1,1,1, 0, AL,  1, 4'b0010};
      vt[7]  = '{32'h0000_0008, 0,0,0,1, 1, GE,  0, 4'b0001};
      vt[8]  = '{32'h0000_0009, 1,0,0,0, 0, LT,  1, 4'b0001};
      vt[9]  = '{32'hA5A5_0001, 1,0,0,1, 1, GE,  1, 4'b1001};
      vt[10] = '{32'h8000_0000, 1,0,0,0, 1, LT,  1, 4'b1000};
      vt[11] = '{32'h1234_5678, 0,1,1,1, 0, GEU, 1, 4'b1000};
      vt[12] = '{32'h0000_0000, 1,1,1,1, 1, NE,  0, 4'b1111};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_result", {32'd0, out_result}, 64'd0);
      check("rst_out_taken", {63'd0, out_taken}, 64'd0);
      check("rst_status", {60'd0, status_nzcv}, 64'd0);
      check("rst_sticky", {63'd0, sticky_ovf}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Vector table, streaming with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         send(vt[i].res, vt[i].n, vt[i].z, vt[i].c, vt[i].v, vt[i].upd, vt[i].cond, vt[i].exp_taken);
         if (i == 0) begin
            check("lat_out_valid", {63'd0, out_valid}, 64'd1);
            check("lat_out_result", {32'd0, out_result}, 64'd0);
         end
         check($sformatf("status_v%0d", i), {60'd0, status_nzcv}, {60'd0, vt[i].exp_nzcv});
         if (vt[i].upd && vt[i].v) exp_sticky = STICKY_EN;
      end
      drain();
      check("tbl_sticky", {63'd0, sticky_ovf}, {63'd0, exp_sticky});

      // Backpressure: two beats fill the FIFO, the third waits for in_ready
      out_ready = 1'b0;
      send(32'd1, 0,0,0,0, 0, AL, 1);
      send(32'd2, 0,0,0,0, 0, AL, 1);
      check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
      drive(32'd3, 0,0,0,0, 0, AL, 1);
      repeat (2) begin
         @(posedge clk); #1;
         check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
         check("bp_hold_result", {32'd0, out_result}, 64'd1);
         check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_rise", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      check("bp_status_kept", {60'd0, status_nzcv}, 64'hF);

      // Sticky overflow sequence
      clear_sticky = 1'b1;
      @(posedge clk); #1;
      clear_sticky = 1'b0;
      check("stk_clear0", {63'd0, sticky_ovf}, 64'd0);
      send(32'h10, 0,0,0,1, 0, AL, 1);
      check("stk_no_upd", {63'd0, sticky_ovf}, 64'd0);
      send(32'h11, 0,0,0,1, 1, AL, 1);
      check("stk_set", {63'd0, sticky_ovf}, {63'd0, STICKY_EN});
      send(32'h12, 0,0,0,0, 1, AL, 1);
      check("stk_persist", {63'd0, sticky_ovf}, {63'd0, STICKY_EN});
      clear_sticky = 1'b1;
      send(32'h13, 0,0,0,1, 1, AL, 1);
      clear_sticky = 1'b0;
      check("stk_set_wins", {63'd0, sticky_ovf}, {63'd0, STICKY_EN});
      clear_sticky = 1'b1;
      @(posedge clk); #1;
      clear_sticky = 1'b0;
      check("stk_clear1", {63'd0, sticky_ovf}, 64'd0);
      drain();

      // Reset with two beats buffered
      out_ready = 1'b0;
      send(32'h20, 1,0,1,0, 1, AL, 1);
      send(32'h21, 0,0,0,0, 0, AL, 1);
      check("mid_full", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_status", {60'd0, status_nzcv}, 64'd0);
      check("mid_rst_sticky", {63'd0, sticky_ovf}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("mid_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (3) begin
         @(posedge clk); #1;
         check("mid_no_stale", {63'd0, out_valid}, 64'd0);
      end
      send(32'h30, 0,1,0,0, 1, EQ, 1);
      drain();
      check("mid_new_status", {60'd0, status_nzcv}, 64'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered consumer stage on the ALU output side. It accepts one ALU result plus the Z/N/C/V flags per beat through a valid/ready handshake and buffers beats in a 2-entry skid FIFO. For each beat it evaluates a branch condition code, keeps the architectural NZCV status register, and presents result plus taken bit downstream. It sits between the ALU and the writeback/branch logic.

Parameters:
WIDTH, 32, data width of result path
RESET_NZCV, 4'b0000, reset value of status register {N,Z,C,V}

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_result  input  WIDTH  ALU result
in_zero  input  1  ALU zero flag
in_negative  input  1  ALU negative flag
in_carry  input  1  ALU carry (borrow on subtract: 1 = A<B unsigned)
in_overflow  input  1  ALU signed overflow
in_update_flags  input  1  beat writes NZCV status
in_cond  input  3  condition code for this beat
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts
out_result  output  WIDTH  buffered result
out_taken  output  1  condition outcome for beat
status_nzcv  output  4  architectural flags {N,Z,C,V}
sticky_ovf  output  1  sticky overflow (optional feature)
clear_sticky  input  1  clears sticky_ovf (optional feature)

Behaviour:
- Reset (rst_n low, async): FIFO empty, out_valid=0, out_result=0, out_taken=0, status_nzcv=RESET_NZCV, sticky_ovf=0, in_ready=1 after release.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- FIFO: 2 entries, count 0..2, registered. in_ready = (count<2), registered, no combinational path from out_ready. out_valid = (count>0). Head entry drives out_result/out_taken.
- Latency: beat accepted in cycle t is visible at the outputs in cycle t+1 when FIFO was empty.
- Simultaneous accept and deliver: count unchanged; allowed at count=1 and count=2 is never accepting. At count=2 with deliver, in_ready rises next cycle.
- Order strictly FIFO; no drops, no duplicates; out_* held stable while out_valid & !out_ready.
- Flag source for condition: if in_update_flags=1 use the beat's flags, else use status_nzcv including all previously accepted beats (update at acceptance, not delivery).
- Status: on accept with in_update_flags=1, status_nzcv <= {in_negative,in_zero,in_carry,in_overflow}; otherwise unchanged.
- in_cond: 000 EQ Z; 001 NE !Z; 010 LT N^V; 011 GE !(N^V); 100 LTU C; 101 GEU !C; 110 ALWAYS 1; 111 NEVER 0. out_taken is computed at acceptance and stored with the entry.
- Reset mid-transfer: all buffered beats discarded; no beat is delivered after reset release until a new accept.
- Inputs are sampled only on accept; values while !in_valid are ignored (X-tolerant).

Optional Feature:
STICKY_OVF_EN: when defined, sticky_ovf is set on any accept with in_overflow=1 and in_update_flags=1; clear_sticky=1 clears it next edge; on a simultaneous set and clear, set wins. When not defined, sticky_ovf is tied 0, clear_sticky is ignored, and no extra register exists.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 2 beats buffered -> out_valid=0, status_nzcv=0000, in_ready=1 after release, no stale beat delivered.
- Single beat: in_result=32'h0000_0000, zero=1, update=1, cond=EQ, out_ready=1 -> next cycle out_valid=1, out_result=0, out_taken=1, status_nzcv=0100.
- Backpressure: out_ready=0, offer 3 beats (results 1,2,3) -> first two accepted, in_ready=0 on the third; release out_ready -> delivered 1,2,3 in order, with the third accepted only after in_ready rises.
- Inherited flags: beat A overflow=1, negative=0, update=1; beat B update=0, cond=LT -> B out_taken=1 (N^V=1); status unchanged by B.
- Unsigned compare: carry=1, update=1, cond=LTU -> taken=1; same beat with cond=GEU -> taken=0; cond=NEVER -> 0 always.
- STICKY_OVF_EN: overflow beat -> sticky_ovf=1 persists across later non-overflow beats; clear_sticky with a concurrent overflow accept -> remains 1; clear alone -> 0. Without the macro -> sticky_ovf stays 0.
